// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: regfile read addressing, operand select, RAW hazard stall, valid/ready handshake with flush.
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and WB bypassing; otherwise per-register pending counters interlock.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_op,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] exm_rd,
    input  logic              exm_rd_we,
    input  logic              exm_is_load,
    input  logic [DATA_W-1:0] exm_data,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_we,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [31:0]       ex_pc,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [3:0]        ex_alu_op
);
    localparam int NREG = 2**ADDR_W;

    logic              ex_valid_reg;
    logic [31:0]       ex_pc_reg;
    logic [DATA_W-1:0] ex_op_a_reg, ex_op_b_reg, ex_imm_reg;
    logic [ADDR_W-1:0] ex_rd_reg;
    logic              ex_rd_we_reg, ex_is_load_reg;
    logic [3:0]        ex_alu_op_reg;

    logic                   stall, fire;
    logic [1:0][ADDR_W-1:0] src_idx;
    logic [1:0]             src_use;
    logic [1:0][DATA_W-1:0] src_rf, src_op;
    logic [1:0]             src_blk, src_haz;

    assign raddr1  = id_rs1;
    assign raddr2  = id_rs2;
    assign src_idx = {id_rs2, id_rs1};
    assign src_use = {id_use_rs2, id_use_rs1};
    assign src_rf  = {rdata2, rdata1};

`ifndef ID_EX_FORWARD_EN
    // Outstanding writers per register; a source is usable only once its count drains to zero.
    logic [NREG-1:0][1:0] pend_reg, pend_next;
    logic                 inc_en, wb_dec_en, fl_dec_en;
    logic                 unused_nofwd;

    assign inc_en    = fire && id_rd_we && (id_rd != '0);
    assign wb_dec_en = wb_we && (wb_waddr != '0);
    assign fl_dec_en = flush && ex_valid_reg && ex_rd_we_reg && (ex_rd_reg != '0);
    assign unused_nofwd = ^{exm_rd, exm_rd_we, exm_is_load, exm_data, wb_wdata};

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            logic inc_hit, wb_hit, fl_hit;
            assign inc_hit = inc_en && (id_rd == ADDR_W'(gi));
            assign wb_hit  = wb_dec_en && (wb_waddr == ADDR_W'(gi));
            assign fl_hit  = fl_dec_en && (ex_rd_reg == ADDR_W'(gi));
            assign pend_next[gi] = pend_reg[gi] + {1'b0, inc_hit} - {1'b0, wb_hit} - {1'b0, fl_hit};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_EX_FORWARD_EN
            // Youngest producer wins; a load still in EX/MEM has no data yet and must not bypass.
            assign src_op[gi] = (src_idx[gi] == '0) ? '0 :
                                (exm_rd_we && !exm_is_load && (exm_rd == src_idx[gi])) ? exm_data :
                                (wb_we && (wb_waddr == src_idx[gi])) ? wb_wdata :
                                src_rf[gi];
            assign src_blk[gi] = (ex_valid_reg && ex_rd_we_reg && (ex_rd_reg == src_idx[gi])) ||
                                 (exm_rd_we && exm_is_load && (exm_rd == src_idx[gi]));
`else
            assign src_op[gi]  = (src_idx[gi] == '0) ? '0 : src_rf[gi];
            assign src_blk[gi] = (pend_reg[src_idx[gi]] != 2'd0);
`endif
            assign src_haz[gi] = src_use[gi] && (src_idx[gi] != '0) && src_blk[gi];
        end
    endgenerate

    assign stall    = |src_haz;
    assign id_ready = !stall && (!ex_valid_reg || ex_ready) && !flush;
    assign fire     = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_reg   <= 1'b0;
            ex_pc_reg      <= '0;
            ex_op_a_reg    <= '0;
            ex_op_b_reg    <= '0;
            ex_imm_reg     <= '0;
            ex_rd_reg      <= '0;
            ex_rd_we_reg   <= 1'b0;
            ex_is_load_reg <= 1'b0;
            ex_alu_op_reg  <= '0;
        end else begin
            if (flush) begin
                ex_valid_reg <= 1'b0;
            end else if (fire) begin
                ex_valid_reg <= 1'b1;
            end else if (ex_ready) begin
                ex_valid_reg <= 1'b0;
            end
            // Data fields only move on an accepted instruction; a flush leaves them stale.
            if (fire) begin
                ex_pc_reg      <= id_pc;
                ex_op_a_reg    <= src_op[0];
                ex_op_b_reg    <= src_op[1];
                ex_imm_reg     <= id_imm;
                ex_rd_reg      <= id_rd;
                ex_rd_we_reg   <= id_rd_we;
                ex_is_load_reg <= id_is_load;
                ex_alu_op_reg  <= id_alu_op;
            end
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_pc      = ex_pc_reg;
    assign ex_op_a    = ex_op_a_reg;
    assign ex_op_b    = ex_op_b_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_rd_we   = ex_rd_we_reg;
    assign ex_is_load = ex_is_load_reg;
    assign ex_alu_op  = ex_alu_op_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed stimulus feeds a transaction scoreboard and a directed-check queue,
// both drained by a single negedge monitor. Regfile reads of index 0 return 999 to prove x0 masking.
`timescale 1ns/1ps
module tb_id_ex_stage;
    localparam int K_IDRDY = 0, K_EXVALID = 1, K_EXPC = 2, K_OPA = 3, K_OPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_ready;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
    logic [31:0] id_imm = '0;
    logic [3:0]  id_alu_op = '0;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  exm_rd = '0;
    logic        exm_rd_we = 1'b0, exm_is_load = 1'b0;
    logic [31:0] exm_data = '0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_we = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid, ex_ready = 1'b1;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we, ex_is_load;
    logic [3:0]  ex_alu_op;

    id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_imm(id_imm), .id_alu_op(id_alu_op),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .exm_rd(exm_rd), .exm_rd_we(exm_rd_we), .exm_is_load(exm_is_load), .exm_data(exm_data),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_we(wb_we), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_alu_op(ex_alu_op)
    );

    always #5 clk = ~clk;

    // Regfile model: write at posedge, old value on a same-cycle read.
    logic [31:0] rf [32] = '{default: 32'd0};
    always @(posedge clk) if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
    assign rdata1 = (raddr1 == 5'd0) ? 32'd999 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd999 : rf[raddr2];

    typedef struct packed {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rd;
        logic        we, ld;
        logic [3:0]  op;
    } txn_t;
    typedef struct { int kind; logic [31:0] exp; } chk_t;

    txn_t sb_q[$];
    chk_t chk_q[$];
    int   total = 0, bad = 0, cyc = 0, idle = 0;
    bit   done = 1'b0;
    chk_t c;
    txn_t e, g;
    logic [31:0] act;

    function automatic logic [31:0] sig_of(input int k);
        case (k)
            K_IDRDY:   return {31'd0, id_ready};
            K_EXVALID: return {31'd0, ex_valid};
            K_EXPC:    return ex_pc;
            K_OPA:     return ex_op_a;
            default:   return ex_op_b;
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_IDRDY:   return "id_ready";
            K_EXVALID: return "ex_valid";
            K_EXPC:    return "ex_pc";
            K_OPA:     return "ex_op_a";
            default:   return "ex_op_b";
        endcase
    endfunction

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        cyc++;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            act = sig_of(c.kind);
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s got=%0h want=%0h t=%0t", kname(c.kind), act, c.exp, $time);
            end
        end
`ifndef ID_EX_FORWARD_EN
        if (id_valid && id_ready && id_rd_we && id_rd != 5'd0) begin
            total++;
            if (dut.pend_reg[id_rd] == 2'd3 && !(wb_we && wb_waddr == id_rd)) begin
                bad++;
                $display("FAIL pend_overflow reg=%0d got=%0d want<3", id_rd, dut.pend_reg[id_rd]);
            end
        end
        if (wb_we && wb_waddr != 5'd0) begin
            total++;
            if (dut.pend_reg[wb_waddr] == 2'd0 && !(id_valid && id_ready && id_rd_we && id_rd == wb_waddr)) begin
                bad++;
                $display("FAIL pend_underflow reg=%0d got=0 want>0", wb_waddr);
            end
        end
`endif
        if (ex_valid && ex_ready) begin
            g = '{ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rd, ex_rd_we, ex_is_load, ex_alu_op};
            total++;
            idle = 0;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL ex_txn unexpected got pc=%0h a=%0h b=%0h want none", ex_pc, ex_op_a, ex_op_b);
            end else begin
                e = sb_q.pop_front();
                if (g !== e)  begin
                    bad++;
                    $display("FAIL ex_txn got pc=%0h a=%0h b=%0h imm=%0h rd=%0d we=%0b ld=%0b op=%0h want pc=%0h a=%0h b=%0h imm=%0h rd=%0d we=%0b ld=%0b op=%0h",
                             g.pc, g.a, g.b, g.imm, g.rd, g.we, g.ld, g.op, e.pc, e.a, e.b, e.imm, e.rd, e.we, e.ld, e.op);
                end else begin
                    $display("txn pc=%0h a=%0d b=%0d imm=%0h rd=%0d ok", g.pc, g.a, g.b, g.imm, g.rd);
                end
            end
        end else if (sb_q.size() > 0) begin
            idle++;
            if (idle == 40) begin
                total++;
                bad++;
                $display("FAIL ex_txn_timeout got no consume want %0d pending", sb_q.size());
            end
        end
        if (cyc > 3000) begin
            total++;
            bad++;
            $display("FAIL watchdog got cycles=%0d want done", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (done) begin
            total++;
            if (sb_q.size() != 0) begin
                bad++;
                $display("FAIL sb_drain got pending=%0d want 0", sb_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int k, input logic [31:0] v);
        chk_t ci;
        ci.kind = k;
        ci.exp  = v;
        chk_q.push_back(ci);
    endtask

    task automatic exp_txn(input logic [31:0] pc, a, b, imm, input logic [4:0] rd,
                           input logic we, ld, input logic [3:0] op);
        sb_q.push_back('{pc, a, b, imm, rd, we, ld, op});
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, rs2, input logic u1, u2,
                          input logic [4:0] rd, input logic we, ld, input logic [31:0] imm, input logic [3:0] op);
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld; id_imm = imm; id_alu_op = op;
        id_valid = 1'b1;
    endtask

    task automatic wait_fire();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (id_ready) break;
        end
        tick();
        id_valid = 1'b0;
    endtask

    // Producer to r, then consumer of r; the bench plays EX/MEM and WB for the producer.
    task automatic raw_case(input logic [31:0] pc, input logic [4:0] r, input logic ld, input logic [31:0] val);
        set_id(pc, 5'd0, 5'd0, 1'b0, 1'b0, r, 1'b1, ld, 32'h0, 4'h2);
        exp_txn(pc, 32'd0, 32'd0, 32'h0, r, 1'b1, ld, 4'h2);
        wait_fire();
        set_id(pc + 32'd4, r, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0, 1'b0, 32'h4, 4'h1);
        exp_txn(pc + 32'd4, val, 32'd0, 32'h4, 5'd12, 1'b0, 1'b0, 4'h1);
        expect_sig(K_IDRDY, 32'd0);
        tick();
        exm_rd = r; exm_rd_we = 1'b1; exm_is_load = ld; exm_data = ld ? 32'hdead_beef : val;
`ifdef ID_EX_FORWARD_EN
        expect_sig(K_IDRDY, {31'd0, !ld});
`else
        expect_sig(K_IDRDY, 32'd0);
`endif
        tick();
        exm_rd = 5'd0; exm_rd_we = 1'b0; exm_is_load = 1'b0; exm_data = 32'd0;
        wb_we = 1'b1; wb_waddr = r; wb_wdata = val;
`ifdef ID_EX_FORWARD_EN
        if (ld) expect_sig(K_IDRDY, 32'd1);
        else begin
            id_valid = 1'b0;
            expect_sig(K_OPA, val);
        end
        tick();
        wb_we = 1'b0;
        if (ld) begin
            id_valid = 1'b0;
            expect_sig(K_OPA, val);
        end
`else
        expect_sig(K_IDRDY, 32'd0);
        tick();
        wb_we = 1'b0;
        expect_sig(K_IDRDY, 32'd1);
        tick();
        id_valid = 1'b0;
        expect_sig(K_OPA, val);
`endif
        tick();
    endtask

    initial begin
        #1 rst = 1'b0;
        expect_sig(K_EXVALID, 32'd0);
        expect_sig(K_EXPC, 32'd0);
        expect_sig(K_OPA, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Preload r19/r23 through issued writers and their writebacks.
        set_id(32'h100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd19, 1'b1, 1'b0, 32'h11, 4'h3);
        exp_txn(32'h100, 32'd0, 32'd0, 32'h11, 5'd19, 1'b1, 1'b0, 4'h3);
        wait_fire();
        set_id(32'h104, 5'd0, 5'd0, 1'b0, 1'b0, 5'd23, 1'b1, 1'b0, 32'h22, 4'h3);
        exp_txn(32'h104, 32'd0, 32'd0, 32'h22, 5'd23, 1'b1, 1'b0, 4'h3);
        wait_fire();
        wb_we = 1'b1; wb_waddr = 5'd19; wb_wdata = 32'd123456;
        tick();
        wb_waddr = 5'd23; wb_wdata = 32'd654321;
        tick();
        wb_we = 1'b0;

        // Independent add of r19, r23.
        set_id(32'h108, 5'd19, 5'd23, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0, 4'h0);
        exp_txn(32'h108, 32'd123456, 32'd654321, 32'h0, 5'd10, 1'b0, 1'b0, 4'h0);
        expect_sig(K_IDRDY, 32'd1);
        wait_fire();
        expect_sig(K_EXVALID, 32'd1);
        expect_sig(K_OPA, 32'd123456);
        expect_sig(K_OPB, 32'd654321);

        // x0 source while regfile, EX/MEM and WB all drive 999 on index 0.
        exm_rd = 5'd0; exm_rd_we = 1'b1; exm_data = 32'd999;
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'd999;
        set_id(32'h10C, 5'd0, 5'd19, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'hffff_fff0, 4'h7);
        exp_txn(32'h10C, 32'd0, 32'd123456, 32'hffff_fff0, 5'd0, 1'b0, 1'b0, 4'h7);
        expect_sig(K_IDRDY, 32'd1);
        wait_fire();
        exm_rd_we = 1'b0; exm_data = 32'd0; wb_we = 1'b0; wb_wdata = 32'd0;
        expect_sig(K_OPA, 32'd0);

        raw_case(32'h110, 5'd5, 1'b0, 32'd77);
        raw_case(32'h118, 5'd7, 1'b1, 32'd42);

        // Back-pressure: EX holds for three cycles.
        ex_ready = 1'b0;
        set_id(32'h130, 5'd19, 5'd23, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h55, 4'h4);
        exp_txn(32'h130, 32'd123456, 32'd654321, 32'h55, 5'd0, 1'b0, 1'b0, 4'h4);
        wait_fire();
        set_id(32'h134, 5'd23, 5'd0, 1'b1, 1'b0, 5'd13, 1'b0, 1'b0, 32'h66, 4'h5);
        exp_txn(32'h134, 32'd654321, 32'd0, 32'h66, 5'd13, 1'b0, 1'b0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            expect_sig(K_IDRDY, 32'd0);
            expect_sig(K_EXVALID, 32'd1);
            expect_sig(K_EXPC, 32'h130);
            expect_sig(K_OPA, 32'd123456);
            tick();
        end
        ex_ready = 1'b1;
        expect_sig(K_IDRDY, 32'd1);
        tick();
        id_valid = 1'b0;
        expect_sig(K_EXPC, 32'h134);
        expect_sig(K_OPA, 32'd654321);
        tick();

        // Flush a writer of r9; a later reader of r9 must not stall.
        ex_ready = 1'b0;
        set_id(32'h140, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 4'h2);
        wait_fire();
        set_id(32'h144, 5'd9, 5'd19, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0, 32'h0, 4'h6);
        flush = 1'b1;
        expect_sig(K_IDRDY, 32'd0);
        expect_sig(K_EXVALID, 32'd1);
        tick();
        flush = 1'b0;
        expect_sig(K_EXVALID, 32'd0);
        expect_sig(K_IDRDY, 32'd1);
        exp_txn(32'h144, 32'd0, 32'd123456, 32'h0, 5'd14, 1'b0, 1'b0, 4'h6);
        tick();
        id_valid = 1'b0;
        ex_ready = 1'b1;
        expect_sig(K_EXPC, 32'h144);
        expect_sig(K_OPB, 32'd123456);
        tick();

        // Reset mid-stream with a writer of r11 parked in EX.
        ex_ready = 1'b0;
        set_id(32'h150, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 32'h0, 4'h2);
        wait_fire();
        rst = 1'b0;
        expect_sig(K_EXVALID, 32'd0);
        expect_sig(K_EXPC, 32'd0);
        tick();
        rst = 1'b1;
        ex_ready = 1'b1;
        set_id(32'h154, 5'd11, 5'd23, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 32'h77, 4'h8);
        exp_txn(32'h154, 32'd0, 32'd654321, 32'h77, 5'd15, 1'b0, 1'b0, 4'h8);
        expect_sig(K_IDRDY, 32'd1);
        tick();
        id_valid = 1'b0;
        expect_sig(K_EXPC, 32'h154);
        tick();
        tick();
        done = 1'b1;
    end
endmodule
